// File: rtl/i2c_master.sv
// Single-byte I2C master: START, address+R/W, ACK, one data byte, ACK/NACK, STOP.
// Build macro I2C_NACK_ABORT_EN: an address NACK jumps straight to STOP.
module i2c_master #(
    parameter int QTR = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl_out,
    inout  wire        sda_out
);

    localparam int QW = $clog2(QTR);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_ADDR, ST_ACK1, ST_WDATA, ST_RDATA, ST_ACK2, ST_STOP
    } state_t;

    state_t          state_r, state_s;
    logic [QW-1:0]   qcnt_r, qcnt_s;
    logic [1:0]      phase_r, phase_s;
    logic [2:0]      bit_r, bit_s;
    logic [7:0]      shift_r, shift_s;
    logic [7:0]      rdata_r, rdata_s;
    logic [7:0]      wdata_r, wdata_s;
    logic [6:0]      addr_r, addr_s;
    logic            rw_r, rw_s;
    logic            ack_err_r, ack_err_s;
    logic            busy_r, busy_s;
    logic            done_r, done_s;
    logic            scl_r, scl_s;
    logic            sda_oe_r, sda_oe_s;
    logic            tx_bit_s;
    logic            tick_s;
    logic            bit_end_s;
    logic            sda_in_s;
    logic [7:0]      addr_byte_s;

    assign tick_s      = (qcnt_r == QW'(QTR - 1));
    assign bit_end_s   = tick_s && (phase_r == 2'd3);
    assign sda_in_s    = sda_out;
    assign addr_byte_s = {addr_r, rw_r};

    // Request capture, bit timing, sampling and state sequencing
    always_comb begin
        state_s   = state_r;
        qcnt_s    = qcnt_r;
        phase_s   = phase_r;
        bit_s     = bit_r;
        shift_s   = shift_r;
        rdata_s   = rdata_r;
        ack_err_s = ack_err_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        addr_s    = addr_r;
        rw_s      = rw_r;
        wdata_s   = wdata_r;
        if (state_r == ST_IDLE) begin
            qcnt_s  = {QW{1'b0}};
            phase_s = 2'd0;
            if (start) begin
                addr_s    = addr;
                rw_s      = rw;
                wdata_s   = wdata;
                busy_s    = 1'b1;
                ack_err_s = 1'b0;
                state_s   = ST_START;
            end else begin
                busy_s = 1'b0;
            end
        end else begin
            if (tick_s) begin
                qcnt_s  = {QW{1'b0}};
                phase_s = phase_r + 2'd1;
            end else begin
                qcnt_s  = qcnt_r + QW'(1'b1);
            end
            // SDA is sampled on entry to phase 3, while SCL is high
            if (tick_s && (phase_r == 2'd2)) begin
                case (state_r)
                    ST_ACK1:  ack_err_s = ack_err_r | sda_in_s;
                    ST_RDATA: shift_s   = {shift_r[6:0], sda_in_s};
                    ST_ACK2:  ack_err_s = ack_err_r | (sda_in_s & ~rw_r);
                    default:  shift_s   = shift_r;
                endcase
            end else begin
                shift_s = shift_r;
            end
            if (bit_end_s) begin
                case (state_r)
                    ST_START: begin
                        state_s = ST_ADDR;
                        bit_s   = 3'd7;
                    end
                    ST_ADDR: begin
                        if (bit_r == 3'd0) begin
                            state_s = ST_ACK1;
                        end else begin
                            bit_s = bit_r - 3'd1;
                        end
                    end
                    ST_ACK1: begin
                        bit_s = 3'd7;
`ifdef I2C_NACK_ABORT_EN
                        if (ack_err_r) begin
                            state_s = ST_STOP;
                        end else if (rw_r) begin
                            state_s = ST_RDATA;
                        end else begin
                            state_s = ST_WDATA;
                        end
`else
                        if (rw_r) begin
                            state_s = ST_RDATA;
                        end else begin
                            state_s = ST_WDATA;
                        end
`endif
                    end
                    ST_WDATA: begin
                        if (bit_r == 3'd0) begin
                            state_s = ST_ACK2;
                        end else begin
                            bit_s = bit_r - 3'd1;
                        end
                    end
                    ST_RDATA: begin
                        if (bit_r == 3'd0) begin
                            state_s = ST_ACK2;
                            rdata_s = shift_r;
                        end else begin
                            bit_s = bit_r - 3'd1;
                        end
                    end
                    ST_ACK2: state_s = ST_STOP;
                    ST_STOP: begin
                        state_s = ST_IDLE;
                        done_s  = 1'b1;
                        busy_s  = 1'b0;
                    end
                    default: state_s = ST_IDLE;
                endcase
            end else begin
                bit_s = bit_r;
            end
        end
    end

    // Bus pin levels for the upcoming state/phase; SDA only changes in phase 1 of data bits
    always_comb begin
        scl_s    = 1'b1;
        sda_oe_s = sda_oe_r;
        tx_bit_s = 1'b1;
        case (state_s)
            ST_IDLE: begin
                scl_s    = 1'b1;
                sda_oe_s = 1'b0;
            end
            ST_START: begin
                scl_s    = 1'b1;
                sda_oe_s = phase_s[1];
            end
            ST_ADDR, ST_WDATA: begin
                scl_s    = phase_s[1];
                tx_bit_s = (state_s == ST_ADDR) ? addr_byte_s[bit_s] : wdata_r[bit_s];
                if (phase_s == 2'd1) begin
                    sda_oe_s = ~tx_bit_s;
                end else begin
                    sda_oe_s = sda_oe_r;
                end
            end
            ST_ACK1, ST_RDATA, ST_ACK2: begin
                scl_s = phase_s[1];
                if (phase_s == 2'd1) begin
                    sda_oe_s = 1'b0;
                end else begin
                    sda_oe_s = sda_oe_r;
                end
            end
            ST_STOP: begin
                scl_s = phase_s[1];
                if (phase_s == 2'd3) begin
                    sda_oe_s = 1'b0;
                end else if (phase_s[1] == 1'b0) begin
                    sda_oe_s = 1'b1;
                end else begin
                    sda_oe_s = sda_oe_r;
                end
            end
            default: begin
                scl_s    = 1'b1;
                sda_oe_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset releases the bus at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            qcnt_r    <= {QW{1'b0}};
            phase_r   <= 2'd0;
            bit_r     <= 3'd0;
            shift_r   <= 8'h00;
            rdata_r   <= 8'h00;
            wdata_r   <= 8'h00;
            addr_r    <= 7'h00;
            rw_r      <= 1'b0;
            ack_err_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            scl_r     <= 1'b1;
            sda_oe_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            qcnt_r    <= qcnt_s;
            phase_r   <= phase_s;
            bit_r     <= bit_s;
            shift_r   <= shift_s;
            rdata_r   <= rdata_s;
            wdata_r   <= wdata_s;
            addr_r    <= addr_s;
            rw_r      <= rw_s;
            ack_err_r <= ack_err_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            scl_r     <= scl_s;
            sda_oe_r  <= sda_oe_s;
        end
    end

    assign rdata   = rdata_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign ack_err = ack_err_r;
    assign scl_out = scl_r;
    assign sda_out = sda_oe_r ? 1'b0 : 1'bz;

endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
- Single-byte I2C bus master; sits directly upstream of the I2C slave and drives its scl_out / sda_out_s bus pins.
- Accepts one transaction request from the system side: 7-bit address, R/W bit, and one data byte.
- Generates START, address, ACK, data, ACK/NACK and STOP from a divided system clock, then returns read data and status.
- SDA is open-drain: the block drives 0 or releases to Z; the bus has an external pull-up.

Parameters:
- QTR, 4: system clocks per quarter SCL bit period (bit period = 4*QTR clocks); legal range QTR >= 2.

Ports:
- clk      input   1  system clock
- rst_n    input   1  asynchronous active-low reset
- start    input   1  request strobe, sampled on a clk rising edge
- rw       input   1  0 = write byte to slave, 1 = read byte from slave
- addr     input   7  7-bit slave address
- wdata    input   8  byte to write
- rdata    output  8  byte read; valid when done=1 and rw was 1
- busy     output  1  high from request acceptance until done
- done     output  1  one-clock pulse at transaction end
- ack_err  output  1  a slave NACK was seen in this transaction; valid with done
- scl_out  output  1  I2C clock, push-pull; idles high
- sda_out  inout   1  I2C data, open-drain (0 or Z)

Behaviour:
- Reset (async, rst_n=0): scl_out=1, sda_out=Z, busy=0, done=0, ack_err=0, rdata=0, FSM=IDLE, all counters 0.
- Reset asserted mid-transaction: the bus is released immediately; no STOP is generated.
- Request acceptance: start=1 while busy=0 latches addr, rw and wdata, sets busy=1 and clears ack_err. start is ignored while busy=1.
- Timing: a quarter counter (0..QTR-1) produces a tick; a 2-bit phase counter advances one step per tick.
  - phase 0: SCL low.
  - phase 1: SCL low; SDA is updated at the start of this phase.
  - phase 2: SCL rises.
  - phase 3: SCL high; SDA is sampled at the start of this phase.
- FSM states: IDLE, START, ADDR, ACK1, WDATA, RDATA, ACK2, STOP. Each state lasts whole bit periods.
  - START (1 bit): SCL held high; SDA driven 0 at phase 2 (SDA falls while SCL is high).
  - ADDR (8 bits): shift out {addr[6:0], rw}, MSB first; a 3-bit counter runs 7 down to 0. Go to ACK1.
  - ACK1 (1 bit): release SDA and sample it at phase 3. Sampled 1 sets ack_err. Then go to WDATA if rw=0, else RDATA.
  - WDATA (8 bits): shift out wdata, MSB first. Go to ACK2.
  - RDATA (8 bits): release SDA; sample at phase 3 into a shift register, MSB first; load rdata at the end of bit 0. Go to ACK2.
  - ACK2 (1 bit):
    - rw=0: release SDA and sample; sampled 1 sets ack_err.
    - rw=1: master NACKs by releasing SDA (single-byte read).
    - Then go to STOP.
  - STOP (1 bit): SDA driven 0 in phases 0-1; SCL high from phase 2; SDA released at phase 3 (SDA rises while SCL is high). On completion, done=1 for one clock, busy=0, return to IDLE.
- Latency: done pulses exactly 20*4*QTR clocks after the accepting edge (START + 8 + 1 + 8 + 1 + STOP bit periods).
- rdata and ack_err hold their values until the next accepted request. rdata is unchanged by write transactions.
- Only '0' is ever driven onto sda_out; a '1' data bit is sent by releasing to Z.
- No arbitration or clock stretching: scl_out is never read back.

Optional Feature:
- Macro: I2C_NACK_ABORT_EN.
- Defined: a NACK sampled in ACK1 sets ack_err and jumps straight to STOP, skipping the data byte and ACK2. done then pulses 11*4*QTR clocks after acceptance, and rdata is unchanged.
- Undefined: a NACK in ACK1 sets ack_err, but the full 20-bit-period transaction still runs.

Test Plan:
- Reset: rst_n=0 mid-ADDR -> scl_out=1, sda_out=Z, busy=0, done=0, ack_err=0 within the same cycle (asynchronous).
- Write with ACKing slave: addr=7'h2A, rw=0, wdata=8'hA5, QTR=4 -> bus shows START, 0x54, ACK, 0xA5, ACK, STOP; done pulses at exactly 320 clks; ack_err=0.
- Read: addr=7'h2A, rw=1, slave returns 8'h3C -> address byte 0x55 on the bus, master NACKs the data byte, rdata=8'h3C at done, ack_err=0.
- Address NACK (no slave on the bus): addr=7'h11, rw=0 -> ack_err=1. Without I2C_NACK_ABORT_EN, done at 320 clks; with it, done at 176 clks and no data byte on the bus.
- start pulsed while busy=1 with different addr/wdata -> ignored; the in-flight transfer completes unchanged; busy stays high until the original done.
- Back-to-back: start asserted on the cycle after done -> a new START begins, ack_err is cleared on acceptance, and the previous rdata is held until overwritten by a new read.
